// File: rtl/psram_burst_ctrl_p.sv
// Parametrised PSRAM controller: runs power-up wait and the configuration-register
// write, then services synchronous burst reads and writes between the FIFOs and the memory.
module psram_burst_ctrl_p #(
    parameter int                ADDR_W     = 23,
    parameter int                DATA_W     = 16,
    parameter int                LEN_W      = 7,
    parameter int                PWRUP_CYC  = 24000,
    parameter logic [ADDR_W-1:0] CFG_OPCODE = 23'h081D1F,
    parameter int                CFG_WE_CYC = 8,
    parameter int                ADV_CYC    = 2,
    parameter int                LATENCY    = 4,
    parameter int                WAIT_EN    = 1
) (
    input  logic              clk_i,
    input  logic              rst,
    output logic [ADDR_W-1:0] Addr,
    inout  wire  [DATA_W-1:0] DQ,
    output logic              nCE,
    output logic              nOE,
    output logic              nWE,
    output logic              nADV,
    output logic              nLB,
    output logic              nUB,
    output logic              CRE,
    input  logic              mem_wait,
    output logic              mem_clk_en,
    output logic              cfg_done,
    input  logic              brst_go,
    input  logic              brst_wr,
    input  logic [ADDR_W-1:0] brst_addr_in,
    input  logic [LEN_W-1:0]  brst_len,
    output logic              brst_done,
    output logic              brst_ren,
    input  logic [DATA_W-1:0] brst_din,
    output logic              brst_wen,
    output logic [DATA_W-1:0] brst_dout
);

    localparam int PH_MAX_A = (CFG_WE_CYC > ADV_CYC) ? CFG_WE_CYC : ADV_CYC;
    localparam int PH_MAX_B = (LATENCY > 2) ? LATENCY : 2;
    localparam int PH_MAX   = (PH_MAX_A > PH_MAX_B) ? PH_MAX_A : PH_MAX_B;
    localparam int PH_W     = $clog2(PH_MAX) + 1;
    localparam int PW_W     = $clog2(PWRUP_CYC) + 1;

    localparam logic [PW_W-1:0] PW_LAST  = PW_W'(PWRUP_CYC - 1);
    localparam logic [PH_W-1:0] WE_LAST  = PH_W'(CFG_WE_CYC - 1);
    localparam logic [PH_W-1:0] ADV_LAST = PH_W'(ADV_CYC - 1);
    localparam logic [PH_W-1:0] LAT_LAST = PH_W'(LATENCY - 1);
    localparam logic [PH_W-1:0] END_LAST = PH_W'(1);

    typedef enum logic [3:0] {
        S_PWRUP,
        S_CFG_ADR,
        S_CFG_WE,
        S_CFG_END,
        S_IDLE,
        S_ADDR,
        S_LAT,
        S_XFER,
        S_END
    } state_t;

    state_t            state;
    logic [PW_W-1:0]   pwr_cnt;
    logic [PH_W-1:0]   ph_cnt;
    logic [LEN_W-1:0]  wcnt;
    logic [LEN_W-1:0]  len_m1;
    logic              wr_q;
    logic              wait_q;
    logic              stall;

    // len_m1 wraps 0 to all-ones, so a zero length naturally means 2^LEN_W words
    assign stall    = (WAIT_EN != 0) && wait_q;
    assign brst_ren = (state == S_XFER) && wr_q && !stall;
    assign DQ       = ((state == S_XFER) && wr_q) ? brst_din : {DATA_W{1'bz}};

    always_ff @(posedge clk_i) begin
        if (rst) begin
            state      <= S_PWRUP;
            pwr_cnt    <= '0;
            ph_cnt     <= '0;
            wcnt       <= '0;
            len_m1     <= '0;
            wr_q       <= 1'b0;
            wait_q     <= 1'b0;
            Addr       <= '0;
            nCE        <= 1'b1;
            nOE        <= 1'b1;
            nWE        <= 1'b1;
            nADV       <= 1'b1;
            nLB        <= 1'b1;
            nUB        <= 1'b1;
            CRE        <= 1'b0;
            mem_clk_en <= 1'b0;
            cfg_done   <= 1'b0;
            brst_done  <= 1'b1;
            brst_wen   <= 1'b0;
            brst_dout  <= '0;
        end else begin
            wait_q   <= mem_wait;
            brst_wen <= 1'b0;
            case (state)
                S_PWRUP: begin
                    if (pwr_cnt == PW_LAST) begin
                        state <= S_CFG_ADR;
                        CRE   <= 1'b1;
                        nCE   <= 1'b0;
                        nADV  <= 1'b0;
                        Addr  <= CFG_OPCODE;
                    end else begin
                        pwr_cnt <= pwr_cnt + 1'b1;
                    end
                end
                S_CFG_ADR: begin
                    state  <= S_CFG_WE;
                    nADV   <= 1'b1;
                    nWE    <= 1'b0;
                    ph_cnt <= '0;
                end
                S_CFG_WE: begin
                    if (ph_cnt == WE_LAST) begin
                        state <= S_CFG_END;
                        nWE   <= 1'b1;
                        nCE   <= 1'b1;
                        CRE   <= 1'b0;
                        Addr  <= '0;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                S_CFG_END: begin
                    state    <= S_IDLE;
                    cfg_done <= 1'b1;
                end
                S_IDLE: begin
                    if (brst_go) begin
                        state      <= S_ADDR;
                        wr_q       <= brst_wr;
                        len_m1     <= brst_len - 1'b1;
                        brst_done  <= 1'b0;
                        nCE        <= 1'b0;
                        nADV       <= 1'b0;
                        nLB        <= 1'b0;
                        nUB        <= 1'b0;
                        nWE        <= !brst_wr;
                        Addr       <= brst_addr_in;
                        mem_clk_en <= 1'b1;
                        ph_cnt     <= '0;
                    end
                end
                S_ADDR: begin
                    if (ph_cnt == ADV_LAST) begin
                        state  <= S_LAT;
                        nADV   <= 1'b1;
                        nWE    <= 1'b1;
                        nOE    <= wr_q;
                        ph_cnt <= '0;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                S_LAT: begin
                    if (ph_cnt == LAT_LAST) begin
                        state <= S_XFER;
                        wcnt  <= '0;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                S_XFER: begin
                    // A stalled cycle moves nothing; the FIFO head and the memory word both hold
                    if (!stall) begin
                        if (!wr_q) begin
                            brst_dout <= DQ;
                            brst_wen  <= 1'b1;
                        end
                        wcnt <= wcnt + 1'b1;
                        if (wcnt == len_m1) begin
                            state      <= S_END;
                            mem_clk_en <= 1'b0;
                            nCE        <= 1'b1;
                            nOE        <= 1'b1;
                            nLB        <= 1'b1;
                            nUB        <= 1'b1;
                            Addr       <= '0;
                            ph_cnt     <= '0;
                        end
                    end
                end
                S_END: begin
                    if (ph_cnt == END_LAST) begin
                        state     <= S_IDLE;
                        brst_done <= 1'b1;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_PWRUP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psram_burst_ctrl_p.sv
// Bench for psram_burst_ctrl_p: cycle-level reference model of burst timing driven by
// directed and $urandom bursts, plus a second instance with the WAIT pin ignored.
module tb_psram_burst_ctrl_p;

    localparam int ADV = 2;
    localparam int LAT = 4;
    localparam int PWR = 24000;
    localparam int WEC = 8;
    localparam int XS  = 1 + ADV + LAT;

    logic        clk;
    logic        rst;
    logic [22:0] Addr;
    wire  [15:0] dq;
    logic        nCE, nOE, nWE, nADV, nLB, nUB, CRE;
    logic        mem_wait, mem_clk_en, cfg_done;
    logic        brst_go, brst_wr, brst_done, brst_ren, brst_wen;
    logic [22:0] brst_addr_in;
    logic [6:0]  brst_len;
    logic [15:0] brst_din, brst_dout, mem_dq;

    logic [22:0] nw_addr_o;
    wire  [15:0] nw_dq;
    logic        nw_nce, nw_noe, nw_nwe, nw_nadv, nw_nlb, nw_nub, nw_cre;
    logic        nw_wait, nw_clk_en, nw_cfg_done;
    logic        nw_go, nw_wr, nw_done, nw_ren, nw_wen;
    logic [22:0] nw_addr;
    logic [6:0]  nw_len;
    logic [15:0] nw_din, nw_dout;

    int n_cmp = 0;
    int n_bad = 0;

    // The memory model only drives the bus while the controller has output enable low
    assign dq = !nOE ? mem_dq : 16'hzzzz;

    psram_burst_ctrl_p u_dut (
        .clk_i(clk), .rst(rst), .Addr(Addr), .DQ(dq),
        .nCE(nCE), .nOE(nOE), .nWE(nWE), .nADV(nADV), .nLB(nLB), .nUB(nUB), .CRE(CRE),
        .mem_wait(mem_wait), .mem_clk_en(mem_clk_en), .cfg_done(cfg_done),
        .brst_go(brst_go), .brst_wr(brst_wr), .brst_addr_in(brst_addr_in), .brst_len(brst_len),
        .brst_done(brst_done), .brst_ren(brst_ren), .brst_din(brst_din),
        .brst_wen(brst_wen), .brst_dout(brst_dout)
    );

    psram_burst_ctrl_p #(.PWRUP_CYC(40), .WAIT_EN(0)) u_dut_nw (
        .clk_i(clk), .rst(rst), .Addr(nw_addr_o), .DQ(nw_dq),
        .nCE(nw_nce), .nOE(nw_noe), .nWE(nw_nwe), .nADV(nw_nadv), .nLB(nw_nlb), .nUB(nw_nub), .CRE(nw_cre),
        .mem_wait(nw_wait), .mem_clk_en(nw_clk_en), .cfg_done(nw_cfg_done),
        .brst_go(nw_go), .brst_wr(nw_wr), .brst_addr_in(nw_addr), .brst_len(nw_len),
        .brst_done(nw_done), .brst_ren(nw_ren), .brst_din(nw_din),
        .brst_wen(nw_wen), .brst_dout(nw_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic checkResetState(input string pfx);
        checkOutput({pfx, "_nCE"},  32'(nCE),  32'(1));
        checkOutput({pfx, "_nOE"},  32'(nOE),  32'(1));
        checkOutput({pfx, "_nWE"},  32'(nWE),  32'(1));
        checkOutput({pfx, "_nADV"}, 32'(nADV), 32'(1));
        checkOutput({pfx, "_nLB"},  32'(nLB),  32'(1));
        checkOutput({pfx, "_nUB"},  32'(nUB),  32'(1));
        checkOutput({pfx, "_CRE"},  32'(CRE),  32'(0));
        checkOutput({pfx, "_Addr"}, 32'(Addr), 32'(0));
        checkOutput({pfx, "_dq"},   32'(dq),   32'(16'hzzzz));
        checkOutput({pfx, "_clken"}, 32'(mem_clk_en), 32'(0));
        checkOutput({pfx, "_cfg"},  32'(cfg_done), 32'(0));
        checkOutput({pfx, "_done"}, 32'(brst_done), 32'(1));
        checkOutput({pfx, "_ren"},  32'(brst_ren), 32'(0));
        checkOutput({pfx, "_wen"},  32'(brst_wen), 32'(0));
        checkOutput({pfx, "_dout"}, 32'(brst_dout), 32'(0));
    endtask

    // Releases reset and follows the power-up wait and config-register write
    task automatic waitConfig();
        int  done_k = 0;
        int  we_low = 0;
        bit  seen_adr = 1'b0;
        rst = 1'b0;
        for (int k = 1; k <= PWR + 100; k++) begin
            @(negedge clk);
            if (cfg_done) begin
                done_k = k;
                break;
            end
            if (!nWE) begin
                we_low++;
                checkOutput("cfg_we_cre", 32'(CRE), 32'(1));
            end
            if (CRE && !nADV) begin
                seen_adr = 1'b1;
                checkOutput("cfg_addr", 32'(Addr), 32'(23'h081D1F));
            end
        end
        checkOutput("cfg_done_cycle", 32'(done_k >= PWR + WEC + 1 && done_k <= PWR + WEC + 3), 32'(1));
        checkOutput("cfg_we_cycles", 32'(we_low), 32'(WEC));
        checkOutput("cfg_adr_seen", 32'(seen_adr), 32'(1));
    endtask

    // One burst against the cycle model: words move on cycles from XS onward unless the
    // previous cycle's WAIT was high; END takes two cycles, then done.
    task automatic applyStimulus(input bit wr, input logic [22:0] addr, input logic [6:0] len,
                                 input logic [15:0] base, input int stall_a, input int stall_w,
                                 input int go_k, input int abort_k);
        int n, moved, done_at, prev_idx;
        bit wait_prev, cons_prev, cons, stall, active, finished;
        n = (len == 7'd0) ? 128 : int'(len);
        moved = 0; done_at = 0; prev_idx = 0;
        wait_prev = 1'b0; cons_prev = 1'b0; finished = 1'b0;
        brst_go = 1'b1; brst_wr = wr; brst_addr_in = addr; brst_len = len;
        brst_din = base; mem_dq = base; mem_wait = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= n + 100; k++) begin
            @(negedge clk);
            if (abort_k != 0 && k == abort_k + 1) begin
                checkResetState("abort");
                finished = 1'b1;
                break;
            end
            brst_go = (k == go_k);
            if (k == go_k) begin
                brst_wr = ~wr;
                brst_len = 7'd3;
                brst_addr_in = ~addr;
            end
            stall = wait_prev;
            mem_wait = (stall_a >= 0) && (k >= XS + stall_a) && (k < XS + stall_a + stall_w);
            brst_din = 16'(base + moved);
            mem_dq = 16'(base + moved);
            if (abort_k != 0 && k == abort_k) rst = 1'b1;
            #1;
            active = (done_at == 0) || (k < done_at - 2);
            cons = (k >= XS) && (moved < n) && !stall;
            if (k == 1) begin
                checkOutput("adr_addr", 32'(Addr), 32'(addr));
                checkOutput("adr_nadv", 32'(nADV), 32'(0));
                checkOutput("adr_nwe", 32'(nWE), 32'(!wr));
            end
            checkOutput("ren", 32'(brst_ren), 32'(wr && cons));
            checkOutput("wen", 32'(brst_wen), 32'(!wr && cons_prev));
            if (!wr && cons_prev) checkOutput("dout", 32'(brst_dout), 32'(16'(base + prev_idx)));
            if (wr && cons) checkOutput("dq_wr", 32'(dq), 32'(16'(base + moved)));
            checkOutput("done", 32'(brst_done), 32'(done_at != 0 && k >= done_at));
            checkOutput("clk_en", 32'(mem_clk_en), 32'(active));
            checkOutput("nCE", 32'(nCE), 32'(!active));
            checkOutput("nOE", 32'(nOE), 32'(!(!wr && k >= 1 + ADV && active)));
            if (!active) checkOutput("end_dq", 32'(dq), 32'(16'hzzzz));
            if (done_at != 0 && k == done_at) begin
                finished = 1'b1;
                break;
            end
            if (cons) begin
                prev_idx = moved;
                moved++;
                if (moved == n) done_at = k + 3;
            end
            cons_prev = cons;
            wait_prev = mem_wait;
        end
        brst_go = 1'b0;
        mem_wait = 1'b0;
        if (!finished) begin
            checkOutput("burst_timeout", 32'(0), 32'(1));
        end else if (abort_k == 0) begin
            repeat (3) begin
                @(negedge clk);
                checkOutput("idle_done", 32'(brst_done), 32'(1));
                checkOutput("idle_ren", 32'(brst_ren), 32'(0));
                checkOutput("idle_wen", 32'(brst_wen), 32'(0));
            end
        end
    endtask

    // Instance with WAIT ignored: WAIT tied high must not slow the burst
    task automatic noWaitBurst();
        int rens = 0;
        int done_k = 0;
        checkOutput("nw_cfg", 32'(nw_cfg_done), 32'(1));
        nw_go = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            nw_go = 1'b0;
            if (nw_ren) rens++;
            if (nw_done) begin
                done_k = k;
                break;
            end
        end
        checkOutput("nw_done_cycle", 32'(done_k), 32'(XS + 5 + 2));
        checkOutput("nw_ren_count", 32'(rens), 32'(5));
    endtask

    initial begin
        rst = 1'b1;
        brst_go = 1'b0; brst_wr = 1'b0; brst_addr_in = '0; brst_len = '0;
        brst_din = '0; mem_dq = '0; mem_wait = 1'b0;
        nw_go = 1'b0; nw_wr = 1'b1; nw_addr = 23'h40; nw_len = 7'd5;
        nw_din = 16'h1234; nw_wait = 1'b1;
        repeat (3) @(negedge clk);
        checkResetState("rst");
        waitConfig();

        applyStimulus(1'b1, 23'h100, 7'd8, 16'hA000, -1, 0, 0, 0);
        applyStimulus(1'b0, 23'h2000, 7'd0, 16'h0000, -1, 0, 0, 0);
        applyStimulus(1'b1, 23'h300, 7'd4, 16'hB000, 1, 3, 0, 0);
        applyStimulus(1'b0, 23'h400, 7'd10, 16'hC000, -1, 0, XS + 3, 0);

        for (int i = 0; i < 8; i++) begin
            bit          wr;
            logic [6:0]  len;
            int          n, sa, sw, gk;
            wr  = 1'($urandom_range(0, 1));
            len = 7'($urandom_range(0, 24));
            n   = (len == 7'd0) ? 128 : int'(len);
            sa  = -1; sw = 0; gk = 0;
            if (n >= 2 && $urandom_range(0, 1) == 1) begin
                sa = int'($urandom_range(0, n - 2));
                sw = int'($urandom_range(1, 4));
            end
            if (n > 3 && $urandom_range(0, 1) == 1) gk = XS + 2;
            applyStimulus(wr, 23'($urandom), len, 16'($urandom), sa, sw, gk, 0);
        end

        noWaitBurst();

        applyStimulus(1'b1, 23'h500, 7'd20, 16'hD000, -1, 0, 0, 10);
        waitConfig();
        applyStimulus(1'b0, 23'h600, 7'd6, 16'hE000, 2, 2, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/psram_burst_ctrl_p.md
Name: psram_burst_ctrl_p

Overview:
- Parametrised single-clock successor to the PSRAM controller.
- Performs power-up wait and the configuration-register write, then services synchronous burst reads and writes of run-time length between the FIFO side and the memory.
- New over the previous generation: parametrised widths, latency and max burst; per-request burst length; WAIT-pin stall; a single FSM on one clock.
- Sits between camera/display FIFOs and the PSRAM pins; mem_clk_en gates the memory clock in the clock module.

Parameters:
- ADDR_W, 23, memory address width
- DATA_W, 16, DQ width
- LEN_W, 7, brst_len width; value 0 means 2^LEN_W words
- PWRUP_CYC, 24000, power-up wait cycles before configuration
- CFG_OPCODE, 23'h081D1F, value driven on Addr during the config-register write
- CFG_WE_CYC, 8, nWE low cycles for the config write
- ADV_CYC, 2, cycles nADV is held low per burst
- LATENCY, 4, cycles from nADV rising to the first data word
- WAIT_EN, 1, 1 = honour mem_wait stalls

Ports:
- clk_i  in  1  single clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-high
- Addr  out  ADDR_W  memory address
- DQ  inout  DATA_W  memory data
- nCE, nOE, nWE, nADV, nLB, nUB  out  1 each  memory strobes, active low
- CRE  out  1  control register enable
- mem_wait  in  1  memory WAIT pin; high = data not ready
- mem_clk_en  out  1  memory clock gate
- cfg_done  out  1  configuration finished; level
- brst_go  in  1  burst request
- brst_wr  in  1  1 = write, 0 = read
- brst_addr_in  in  ADDR_W  burst start address
- brst_len  in  LEN_W  words in the burst
- brst_done  out  1  high when idle/ready
- brst_ren  out  1  pop strobe to a first-word-fall-through (FWFT) write FIFO
- brst_din  in  DATA_W  write data from the FIFO
- brst_wen  out  1  push strobe to the read FIFO
- brst_dout  out  DATA_W  read data, registered

Behaviour:
- Reset: all strobes 1, CRE 0, Addr 0, DQ hi-Z, mem_clk_en 0, cfg_done 0, brst_done 1, brst_ren/brst_wen 0, brst_dout 0, FSM in PWRUP, counters cleared.
- Reset asserted mid-burst: outputs return to reset values on the next edge; configuration reruns.
- PWRUP: counts PWRUP_CYC cycles, then CFG_ADR.
- CFG_ADR, 1 cycle: CRE=1, nCE=0, nADV=0, Addr=CFG_OPCODE.
- CFG_WE, CFG_WE_CYC cycles: nADV=1, nWE=0, Addr held.
- CFG_END, 1 cycle: nWE=1, nCE=1, CRE=0, Addr=0. cfg_done=1 from the next cycle and stays high until reset.
- IDLE: brst_go=1 latches brst_wr, brst_addr_in and brst_len (0 → 2^LEN_W). brst_done=0 from the next cycle. brst_go while not in IDLE is ignored.
- ADDR, ADV_CYC cycles: nCE=0, nADV=0, nLB=nUB=0, Addr=latched address, mem_clk_en=1, nWE=0 if write.
- LAT, LATENCY cycles: nADV=1, nWE=1; nOE=0 if read.
- XFER: mem_wait is registered once as wait_q; stall = WAIT_EN & wait_q. Each non-stall cycle moves one word and increments the word counter. The counter is held during stall.
- XFER write: DQ driven with brst_din for the whole XFER state. brst_ren = XFER & wr & ~stall (combinational from registered state and wait_q).
- XFER read: in each non-stall cycle, DQ is registered into brst_dout; brst_wen pulses one cycle later. DQ is never driven during a read.
- XFER exit: after the last word → END.
- END, 2 cycles: mem_clk_en=0, nCE=nOE=nLB=nUB=1, DQ hi-Z, Addr=0. The last read brst_wen lands in the first END cycle.
- END exit: → IDLE with brst_done=1.
- Burst latency, no stall: go sampled at edge t0 → brst_done high at t0+1+ADV_CYC+LATENCY+N+2.
- No address wrap handling; the requester keeps bursts within a row.
- brst_ren and brst_wen are never high together. DQ is driven only during config-free write XFER.

Test Plan:
- Reset then idle: cfg_done rises at cycle PWRUP_CYC+CFG_WE_CYC+2 (±1). During CFG_ADR, Addr=23'h081D1F with CRE=1, and nWE is low for exactly 8 cycles.
- Write burst, brst_len=8, addr 0x100, FIFO holds 0xA000..0xA007, defaults: brst_ren high for 8 consecutive cycles starting 7 cycles after go; DQ shows 0xA000..0xA007 in order; brst_done high 17 cycles after go.
- Read burst, brst_len=0 (128 words), memory model returns incrementing data from 0x0000: 128 brst_wen pulses; brst_dout 0x0000..0x007F in order; nOE low from LAT through XFER.
- Write burst len 4 with mem_wait high for 3 cycles after the 2nd word: brst_ren low for exactly 3 cycles; no word lost or duplicated; done delayed by 3 cycles.
- brst_go pulsed during a running read: ignored, with exactly one brst_done rise. Reset asserted mid-XFER: next cycle nCE=1, DQ hi-Z, mem_clk_en=0, cfg_done=0.
- WAIT_EN=0 with mem_wait held high: the burst completes in nominal cycle count.
